// File: rtl/bp_pkg.sv
// Shared types for the branch resolve queue.
// Entry layout, size defaults and control states.
package bp_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_PCW   = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } brq_state_e;

  typedef struct packed {
    logic [BP_PCW-1:0] pc;
    logic [BP_PCW-1:0] target;
    logic              taken;
    logic              hit;
  } brq_entry_t;

endpackage

// File: rtl/brq_storage.sv
// Prediction entry array for the branch resolve queue.
// One write port, one asynchronous read port, no reset.
module brq_storage
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  brq_entry_t               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output brq_entry_t               rdata_o
);

  brq_entry_t mem_q [DEPTH];

  // Write the pushed prediction into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch predictions checked against EX.
// Raises a one-cycle flush on mispredict and trains the BP.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PCW   = BP_PCW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [PCW-1:0]         push_pc,
  input  logic [PCW-1:0]         push_target,
  input  logic                   push_taken,
  input  logic                   push_hit,
  output logic                   push_ready,
  input  logic                   res_valid,
  input  logic                   res_is_branch,
  input  logic                   res_taken,
  input  logic [PCW-1:0]         res_target,
  output logic                   flush,
  output logic [PCW-1:0]         flush_pc,
  output logic                   upd_valid,
  output logic [PCW-1:0]         upd_pc,
  output logic                   upd_taken,
  output logic [PCW-1:0]         upd_target,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            mispredict_cnt,
  output logic                   underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  brq_state_e      state_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            flush_q, upd_valid_q, upd_taken_q;
  logic [PCW-1:0]  flush_pc_q, upd_pc_q, upd_target_q;
  logic [15:0]     mis_cnt_q;
  logic            uflow_q;

  brq_entry_t      wr_entry, head;
  logic            push_ok, pop, uflow_d, mis, mispred;
  logic [PCW-1:0]  flush_pc_d;
  logic            unused_hit;

  assign push_ready = (count_q < CW'(DEPTH)) && (state_q == ST_RUN);
  assign push_ok    = push_valid && push_ready;

  assign wr_entry.pc     = push_pc;
  assign wr_entry.target = push_target;
  assign wr_entry.taken  = push_taken;
  assign wr_entry.hit    = push_hit;

  brq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign unused_hit = head.hit;

  // Compare the head prediction with the EX outcome.
  always_comb begin
    pop        = 1'b0;
    uflow_d    = 1'b0;
    mis        = 1'b0;
    flush_pc_d = head.pc + PCW'(4);
    if (state_q == ST_RUN && res_valid) begin
      pop     = (count_q != '0);
      uflow_d = (count_q == '0);
    end
    unique case (1'b1)
      res_is_branch:
        mis = (res_taken != head.taken) ||
              (res_taken && (res_target != head.target));
      default:
        mis = head.taken;
    endcase
    if (res_is_branch && res_taken) flush_pc_d = res_target;
    mispred = pop && mis;
  end

  // Control FSM, queue pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      mis_cnt_q    <= '0;
      uflow_q      <= 1'b0;
    end else begin
      flush_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (uflow_d) uflow_q <= 1'b1;
          if (pop && res_is_branch) begin
            upd_valid_q  <= 1'b1;
            upd_pc_q     <= head.pc;
            upd_taken_q  <= res_taken;
            upd_target_q <= res_target;
          end
          if (mispred) begin
            state_q    <= ST_FLUSH;
            flush_q    <= 1'b1;
            flush_pc_q <= flush_pc_d;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            if (mis_cnt_q != 16'hFFFF)
              mis_cnt_q <= mis_cnt_q + 16'd1;
          end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + CW'(push_ok) - CW'(pop);
          end
        end
        ST_FLUSH: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign flush          = flush_q;
  assign flush_pc       = flush_pc_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign count          = count_q;
  assign mispredict_cnt = mis_cnt_q;
  assign underflow_err  = uflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue.
// Each scenario task drives vectors and checks inline.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_target = '0;
  logic        push_taken = 1'b0;
  logic        push_hit = 1'b0;
  logic        push_ready;
  logic        res_valid = 1'b0;
  logic        res_is_branch = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        flush;
  logic [31:0] flush_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [2:0]  count;
  logic [15:0] mispredict_cnt;
  logic        underflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_pc        (push_pc),
    .push_target    (push_target),
    .push_taken     (push_taken),
    .push_hit       (push_hit),
    .push_ready     (push_ready),
    .res_valid      (res_valid),
    .res_is_branch  (res_is_branch),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .count          (count),
    .mispredict_cnt (mispredict_cnt),
    .underflow_err  (underflow_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid    = 1'b0;
    res_valid     = 1'b0;
    res_is_branch = 1'b0;
    res_taken     = 1'b0;
    res_target    = '0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic [31:0] tg,
                          input logic tk);
    push_valid  = 1'b1;
    push_pc     = pc;
    push_target = tg;
    push_taken  = tk;
    push_hit    = tk;
  endtask

  task automatic set_res(input logic br, input logic tk,
                         input logic [31:0] tg);
    res_valid     = 1'b1;
    res_is_branch = br;
    res_taken     = tk;
    res_target    = tg;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    step();
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", push_ready); end
    checks++; if (flush !== 1'b0 || upd_valid !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b exp 00", flush, upd_valid); end
    checks++; if (mispredict_cnt !== 16'd0 || underflow_err !== 1'b0) begin errors++; $display("FAIL rst_stat got %h/%b exp 0/0", mispredict_cnt, underflow_err); end
    checks++; if (flush_pc !== 32'd0 || upd_pc !== 32'd0) begin errors++; $display("FAIL rst_pcs got %h/%h exp 0/0", flush_pc, upd_pc); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_correct_branch();
    set_push(32'h10, 32'h40, 1'b1);
    step();
    idle();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL cb_count1 got %0d exp 1", count); end
    set_res(1'b1, 1'b1, 32'h40);
    step();
    idle();
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL cb_upd_valid got %b exp 1", upd_valid); end
    checks++; if (upd_pc !== 32'h10) begin errors++; $display("FAIL cb_upd_pc got %h exp 10", upd_pc); end
    checks++; if (upd_taken !== 1'b1 || upd_target !== 32'h40) begin errors++; $display("FAIL cb_upd_tt got %b/%h exp 1/40", upd_taken, upd_target); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL cb_flush got %b exp 0", flush); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL cb_count0 got %0d exp 0", count); end
    step();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL cb_upd_pulse got %b exp 0", upd_valid); end
  endtask

  task automatic test_mispredict();
    set_push(32'h20, 32'h24, 1'b0);
    step();
    idle();
    set_res(1'b1, 1'b1, 32'h80);
    step();
    idle();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mp_flush got %b exp 1", flush); end
    checks++; if (flush_pc !== 32'h80) begin errors++; $display("FAIL mp_flush_pc got %h exp 80", flush_pc); end
    checks++; if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL mp_cnt got %0d exp 1", mispredict_cnt); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL mp_ready_flush got %b exp 0", push_ready); end
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h20) begin errors++; $display("FAIL mp_upd got %b/%h exp 1/20", upd_valid, upd_pc); end
    step();
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL mp_ready_run got %b exp 1", push_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mp_flush_pulse got %b exp 0", flush); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h120;
    exp_pc[1] = 32'h130;
    exp_pc[2] = 32'h150;
    exp_pc[3] = 32'h160;
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 32'(i) * 32'h10, 32'h0, 1'b0);
      step();
    end
    idle();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fw_count_full got %0d exp 4", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fw_ready_full got %b exp 0", push_ready); end
    set_push(32'h140, 32'h0, 1'b0);
    step();
    idle();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fw_fifth_push got %0d exp 4", count); end
    set_res(1'b1, 1'b0, 32'h0);
    step();
    idle();
    checks++; if (count !== 3'd3 || upd_pc !== 32'h100) begin errors++; $display("FAIL fw_pop0 got %0d/%h exp 3/100", count, upd_pc); end
    set_res(1'b1, 1'b0, 32'h0);
    set_push(32'h150, 32'h0, 1'b0);
    step();
    idle();
    checks++; if (count !== 3'd3 || upd_pc !== 32'h110) begin errors++; $display("FAIL fw_pop_push got %0d/%h exp 3/110", count, upd_pc); end
    set_push(32'h160, 32'h0, 1'b0);
    step();
    idle();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fw_refill got %0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, 1'b0, 32'h0);
      step();
      idle();
      checks++; if (upd_valid !== 1'b1 || upd_pc !== exp_pc[i] || flush !== 1'b0) begin errors++; $display("FAIL fw_order%0d got %b/%h/%b exp 1/%h/0", i, upd_valid, upd_pc, flush, exp_pc[i]); end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fw_drained got %0d exp 0", count); end
  endtask

  task automatic test_flush_queue();
    set_push(32'h200, 32'h104, 1'b1);
    step();
    set_push(32'h210, 32'h214, 1'b0);
    step();
    set_push(32'h220, 32'h224, 1'b0);
    step();
    idle();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fq_count3 got %0d exp 3", count); end
    set_res(1'b1, 1'b1, 32'h100);
    step();
    idle();
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin errors++; $display("FAIL fq_flush got %b/%h exp 1/100", flush, flush_pc); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fq_count_flush got %0d exp 0", count); end
    checks++; if (mispredict_cnt !== 16'd2) begin errors++; $display("FAIL fq_cnt got %0d exp 2", mispredict_cnt); end
    set_res(1'b1, 1'b0, 32'h0);
    set_push(32'h300, 32'h0, 1'b0);
    step();
    idle();
    checks++; if (flush !== 1'b0 || upd_valid !== 1'b0) begin errors++; $display("FAIL fq_ignored got %b%b exp 00", flush, upd_valid); end
    checks++; if (count !== 3'd0 || underflow_err !== 1'b0) begin errors++; $display("FAIL fq_ignored_st got %0d/%b exp 0/0", count, underflow_err); end
  endtask

  task automatic test_nonbranch();
    set_push(32'h300, 32'h500, 1'b1);
    step();
    idle();
    set_res(1'b0, 1'b0, 32'h0);
    step();
    idle();
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h304) begin errors++; $display("FAIL nb_flush got %b/%h exp 1/304", flush, flush_pc); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL nb_upd got %b exp 0", upd_valid); end
    checks++; if (mispredict_cnt !== 16'd3) begin errors++; $display("FAIL nb_cnt got %0d exp 3", mispredict_cnt); end
    step();
    set_push(32'hFFFF_FFFC, 32'h8, 1'b1);
    step();
    idle();
    set_res(1'b0, 1'b0, 32'h0);
    step();
    idle();
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h0) begin errors++; $display("FAIL nb_wrap got %b/%h exp 1/0", flush, flush_pc); end
    step();
  endtask

  task automatic test_underflow_reset();
    set_res(1'b1, 1'b1, 32'h0);
    step();
    idle();
    checks++; if (underflow_err !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL uf_set got %b/%b exp 1/0", underflow_err, upd_valid); end
    step();
    step();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow_err); end
    set_push(32'h400, 32'h404, 1'b0);
    step();
    idle();
    set_res(1'b1, 1'b1, 32'h800);
    step();
    idle();
    checks++; if (flush !== 1'b1 || upd_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b%b exp 11", flush, upd_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || upd_valid !== 1'b0) begin errors++; $display("FAIL ar_pulses got %b%b exp 00", flush, upd_valid); end
    checks++; if (flush_pc !== 32'h0 || upd_pc !== 32'h0 || upd_target !== 32'h0 || upd_taken !== 1'b0) begin errors++; $display("FAIL ar_pcs got %h/%h/%h/%b exp 0", flush_pc, upd_pc, upd_target, upd_taken); end
    checks++; if (mispredict_cnt !== 16'd0 || underflow_err !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL ar_stat got %0d/%b/%0d exp 0/0/0", mispredict_cnt, underflow_err, count); end
    rst = 1'b1;
    step();
    checks++; if (push_ready !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL ar_after got %b/%0d exp 1/0", push_ready, count); end
  endtask

  initial begin
    test_reset();
    test_correct_branch();
    test_mispredict();
    test_full_wrap();
    test_flush_queue();
    test_nonbranch();
    test_underflow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
